// File: rtl/mips_pkg.sv
// Shared datapath constants: default register-file geometry and the hardwired zero index.
package mips_pkg;
   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned REG_ZERO   = 0;
endpackage

// File: rtl/reg_word.sv
// One storage word of the register file: load on en, synchronous active-high clear.
module reg_word
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with register 0 hardwired to zero.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              reg_write,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] w_q [DEPTH];

   // Index 0 has no storage; every other word gets a one-hot write enable.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      if (i == REG_ZERO) begin : g_zero
         assign w_q[i] = '0;
      end else begin : g_reg
         logic w_en;
         assign w_en = reg_write & (write_reg == ADDR_W'(i));
         reg_word #(.DATA_W(DATA_W)) u_word (
            .clk   (clk),
            .reset (reset),
            .en    (w_en),
            .d     (write_data),
            .q     (w_q[i])
         );
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic w_fwd;
   assign w_fwd = reg_write & ~reset & (write_reg != ADDR_W'(REG_ZERO));

   // A read of the word being written this cycle sees the incoming value.
   always_comb begin
      read_data1 = w_q[read_reg1];
      read_data2 = w_q[read_reg2];
      if (w_fwd && (read_reg1 == write_reg)) read_data1 = write_data;
      if (w_fwd && (read_reg2 == write_reg)) read_data2 = write_data;
   end
`else
   assign read_data1 = w_q[read_reg1];
   assign read_data2 = w_q[read_reg2];
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file; expected values follow REGFILE_WRITE_BYPASS_EN.
module tb_register_file;

   logic        clk;
   logic        reset;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        reg_write;
   logic [31:0] read_data1;
   logic [31:0] read_data2;

   int checks = 0;
   int errors = 0;

   register_file dut (
      .clk        (clk),
      .reset      (reset),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .write_reg  (write_reg),
      .write_data (write_data),
      .reg_write  (reg_write),
      .read_data1 (read_data1),
      .read_data2 (read_data2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [31:0] val);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = val;
      step();
      reg_write  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; reg_write = 1'b0;
      read_reg1 = '0; read_reg2 = '0; write_reg = '0; write_data = '0;
      step();
      reset = 1'b0;

      // Reset state
      read_reg1 = 5'd5; read_reg2 = 5'd31; #1;
      check("reset_rd1_r5",  read_data1, 32'h0);
      check("reset_rd2_r31", read_data2, 32'h0);

      // Basic write then dual-port read of the same register
      wr(5'd8, 32'hDEAD_BEEF);
      read_reg1 = 5'd8; read_reg2 = 5'd8; #1;
      check("wr8_rd1", read_data1, 32'hDEAD_BEEF);
      check("wr8_rd2", read_data2, 32'hDEAD_BEEF);

      // Writes to register 0 are discarded, including no forwarding
      reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
      read_reg1 = 5'd0; #1;
      check("zero_same_cycle", read_data1, 32'h0);
      step();
      reg_write = 1'b0; #1;
      check("zero_after", read_data1, 32'h0);
      check("r8_unchanged", read_data2, 32'hDEAD_BEEF);

      // Reset has priority over a same-cycle write
      wr(5'd3, 32'h11);
      read_reg1 = 5'd3; #1;
      check("r3_loaded", read_data1, 32'h11);
      reset = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hFF;
      step();
      reset = 1'b0; reg_write = 1'b0; #1;
      check("r3_reset_prio", read_data1, 32'h0);
      check("r8_cleared",    read_data2, 32'h0);

      // Read-during-write
      wr(5'd9, 32'hA);
      read_reg1 = 5'd9; read_reg2 = 5'd3;
      reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hB; #1;
      check("rdw_same_cycle", read_data1, BYP ? 32'hB : 32'hA);
      check("rdw_other_port", read_data2, 32'h0);
      step();
      reg_write = 1'b0; #1;
      check("rdw_next_cycle", read_data1, 32'hB);

      // Forwarding is suppressed while reset is asserted
      reset = 1'b1; reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hC; #1;
      check("rst_no_bypass", read_data1, 32'hB);
      step();
      reset = 1'b0; reg_write = 1'b0; #1;
      check("r9_after_reset", read_data1, 32'h0);

      // Back-to-back writes to the top register keep only the last value
      read_reg2 = 5'd31;
      wr(5'd31, 32'h1);
      reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h2; #1;
      check("b2b_in_flight", read_data2, BYP ? 32'h2 : 32'h1);
      step();
      reg_write = 1'b0; #1;
      check("b2b_last", read_data2, 32'h2);

      // Disabled write leaves the register alone
      write_reg = 5'd31; write_data = 32'h55; reg_write = 1'b0;
      step();
      check("no_we_hold", read_data2, 32'h2);

      // Independent registers at the index extremes
      wr(5'd1, 32'hFFFF_FFFF);
      wr(5'd30, 32'h8000_0001);
      read_reg1 = 5'd1; read_reg2 = 5'd30; #1;
      check("r1_val",  read_data1, 32'hFFFF_FFFF);
      check("r30_val", read_data2, 32'h8000_0001);
      read_reg1 = 5'd31; read_reg2 = 5'd0; #1;
      check("r31_val", read_data1, 32'h2);
      check("r0_val",  read_data2, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register index width; depth = 2**ADDR_W (32).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port read_reg1  input  ADDR_W  port-1 read index (rs).
REQ-006 SHALL have port read_reg2  input  ADDR_W  port-2 read index (rt).
REQ-007 SHALL have port write_reg  input  ADDR_W  write index (rd/rt).
REQ-008 SHALL have port write_data  input  DATA_W  write value.
REQ-009 SHALL have port reg_write  input  1  write enable, sampled at rising clk.
REQ-010 SHALL have port read_data1  output  DATA_W  port-1 read value.
REQ-011 SHALL have port read_data2  output  DATA_W  port-2 read value.

Function
REQ-012 SHALL hold 2**ADDR_W registers of DATA_W bits each.
REQ-013 SHALL update register[write_reg] <= write_data at rising clk when reg_write=1 and reset=0; otherwise no register changes.
REQ-014 SHALL ignore writes to index 0; register 0 always reads 0.
REQ-015 SHALL produce read_data1/read_data2 combinationally from the read indices; zero-cycle read latency.
REQ-016 SHALL allow both read ports to address the same register, returning identical values.
REQ-017 SHALL, on a read-during-write to the same nonzero index without bypass, return the pre-write value in that cycle and the new value from the next cycle.
REQ-018 SHALL, for back-to-back writes to one index, retain only the last value written.
REQ-019 SHALL accept a write on every cycle; there is no busy or stall condition.

Reset
REQ-020 SHALL clear every register to 0 at the rising clk edge where reset=1.
REQ-021 SHALL give reset priority over reg_write in the same cycle; the write is dropped.
REQ-022 SHALL drive read outputs as 0 from the first clk edge after reset is asserted until a subsequent write.
REQ-023 SHALL suppress bypass forwarding while reset=1.

Configuration
REQ-024 SHALL support the macro REGFILE_WRITE_BYPASS_EN.
REQ-025 SHALL, with REGFILE_WRITE_BYPASS_EN defined, forward write_data to any read port whose index equals write_reg when reg_write=1, reset=0 and write_reg != 0.
REQ-026 SHALL, without REGFILE_WRITE_BYPASS_EN, behave per REQ-017 and contain no forwarding logic.

Structure
REQ-027 SHALL take DATA_W and ADDR_W defaults and the constant REG_ZERO (index 0) from the shared package mips_pkg.
REQ-028 SHALL build each storage word from sub-module reg_word: a DATA_W-bit register with ports clk, reset, en, d, q, a synchronous active-high reset, and a load on en.
REQ-029 SHALL generate word-enable decode in register_file: en[i] = reg_write & (write_reg == i) & (i != 0).

Verification
REQ-030 Reset: reset=1 for 1 clk, then read_reg1=5, read_reg2=31 -> read_data1=0, read_data2=0.
REQ-031 Write/read: write 0xDEADBEEF to reg 8, next cycle read_reg1=8, read_reg2=8 -> both outputs 0xDEADBEEF.
REQ-032 Zero register: write 0x12345678 to reg 0, then read_reg1=0 -> read_data1=0.
REQ-033 Reset priority: reg 3 holds 0x11; reset=1 and reg_write=1 with write_data=0xFF to reg 3 in the same cycle -> reg 3 reads 0 afterwards.
REQ-034 Read-during-write: reg 9 holds 0xA; write 0xB to reg 9 with read_reg1=9 -> read_data1=0xB in that cycle with REGFILE_WRITE_BYPASS_EN, 0xA without; 0xB the next cycle in both builds.
REQ-035 Back-to-back: write 1 then 2 to reg 31 on consecutive cycles -> read_data2=2 with read_reg2=31.
